// File: rtl/communication.sv
// Serial transceiver: 8N1 transmitter and mid-bit-sampling receiver on one clock.
// Frame is start(0), 8 data bits LSB first, stop(1); each bit lasts BIT_CYCLES clocks.
//
// Transmitter states
//   state    | meaning
//   TX_IDLE  | line held high, waiting for a load rising edge with transEn=1
//   TX_SEND  | shifting the 10-bit frame out, BIT_CYCLES clocks per bit
//
// Receiver states
//   state    | meaning
//   RX_IDLE  | waiting for a synchronized 1->0 transition on the line
//   RX_START | counting to mid start bit, confirming the line is still low
//   RX_DATA  | sampling eight data bits at mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; a high stop commits the character
module communication #(
  parameter int BIT_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  input  logic [7:0] SW,
  input  logic       load,
  input  logic       transEn,
  input  logic [7:0] parallelDataOut,
  input  logic       dataIn,
  output logic       dataOut,
  output logic [7:0] parallelDataIn,
  output logic       charSent,
  output logic       charReceived,
  output logic [7:0] LEDR
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic rst_n;
  assign rst_n = KEY[0];

  logic unused_sw;
  assign unused_sw = ^SW;

  // ---------------- transmitter ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [9:0]      tx_frame_q, tx_frame_d;
  logic            tx_dout_q, tx_dout_d;
  logic            tx_sent_q, tx_sent_d;
  logic            load_q;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_frame_q <= '0;
      tx_dout_q  <= 1'b1;
      tx_sent_q  <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      tx_dout_q  <= tx_dout_d;
      tx_sent_q  <= tx_sent_d;
      load_q     <= load;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    tx_dout_d  = 1'b1;
    tx_sent_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (load && !load_q && transEn) begin
          tx_frame_d = {1'b1, parallelDataOut, 1'b0};
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        // tx_bit_q reaching 10 means the stop bit has had its full period
        if (tx_bit_q == 4'd10) begin
          tx_state_d = TX_IDLE;
          tx_sent_d  = 1'b1;
        end else begin
          tx_dout_d = tx_frame_q[0];
          if (tx_cnt_q == '0) begin
            tx_cnt_d   = BIT_LAST;
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_frame_d = {1'b1, tx_frame_q[9:1]};
          end else begin
            tx_cnt_d = tx_cnt_q - 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_commit_q, rx_commit_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [7:0]      rx_data_q;
  logic            rx_recv_q;

  // Synchronizer resets to the idle level so reset never looks like a start edge
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_commit_q <= 1'b0;
      rx_data_q   <= '0;
      rx_recv_q   <= 1'b0;
    end else begin
      sync1_q     <= dataIn;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_commit_q <= rx_commit_d;
      rx_recv_q   <= rx_commit_q;
      if (rx_commit_q) begin
        rx_data_q <= rx_shift_q;
      end
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_commit_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Needs a high-then-low pair, so a line stuck low after a framing error never re-arms
        if (prev_q && !sync2_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!sync2_q) begin
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_commit_d = sync2_q;
          rx_state_d  = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign dataOut        = tx_dout_q;
  assign charSent       = tx_sent_q;
  assign parallelDataIn = rx_data_q;
  assign charReceived   = rx_recv_q;
  assign LEDR           = rx_data_q;

endmodule

// File: tb/tb_communication.sv
// Directed bench for the serial transceiver: table of loopback frames plus
// hand-written glitch, framing-error, ignored-load and mid-frame reset sequences.
module tb_communication;

  logic       clk;
  logic [0:0] key;
  logic [7:0] sw;
  logic       load;
  logic       trans_en;
  logic [7:0] pdo;
  logic       din_drv;
  logic       loop_en;
  wire        din;
  logic       dout;
  logic [7:0] pdi;
  logic       char_sent;
  logic       char_recv;
  logic [7:0] ledr;

  assign din = loop_en ? dout : din_drv;

  communication #(.BIT_CYCLES(16)) dut (
    .CLOCK_50        (clk),
    .KEY             (key),
    .SW              (sw),
    .load            (load),
    .transEn         (trans_en),
    .parallelDataOut (pdo),
    .dataIn          (din),
    .dataOut         (dout),
    .parallelDataIn  (pdi),
    .charSent        (char_sent),
    .charReceived    (char_recv),
    .LEDR            (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad = 0;
  int sent_seen = 0;
  int recv_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line level per bit period, [0] transmitted first
    int         hold;    // clocks load stays high
    bit         disturb; // extra load edge and transEn drop mid-frame
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (char_sent) sent_seen++;
      if (char_recv) recv_seen++;
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   bad_cyc, sent_n, sent_at, recv_n, idx;
    logic e;
    bad_cyc = 0; sent_n = 0; sent_at = -1; recv_n = 0;
    loop_en  = 1'b1;
    trans_en = 1'b1;
    pdo      = v.data;
    load     = 1'b1;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      e = 1'b1;
      if (c >= 1 && c <= 160) begin
        idx = (c - 1) / 16;
        e = v.frame[idx];
      end
      if (dout !== e) bad_cyc++;
      if (char_sent) begin sent_n++; sent_at = c; end
      if (char_recv) recv_n++;
      if (c == v.hold - 1) load = 1'b0;
      if (v.disturb) begin
        if (c == 20) load = 1'b0;
        if (c == 40) begin load = 1'b1; pdo = ~v.data; end
        if (c == 60) trans_en = 1'b0;
      end
    end
    load = 1'b0;
    check({tag, "_line_bad_cycles"}, bad_cyc, 0);
    check({tag, "_sent_pulses"}, sent_n, 1);
    check({tag, "_sent_cycle"}, sent_at, 161);
    check({tag, "_recv_pulses"}, recv_n, 1);
    check({tag, "_pdi"}, pdi, v.data);
    check({tag, "_ledr"}, ledr, v.data);
    step(3);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    din_drv = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      din_drv = b[i];
      step(16);
    end
    din_drv = stop_bit;
    step(16);
  endtask

  initial begin
    int s0, r0, bad_cyc;

    vecs[0] = '{8'h72, 10'b1011100100, 16,  1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 190, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 16,  1'b0};
    vecs[3] = '{8'hA5, 10'b1101001010, 16,  1'b1};
    vecs[4] = '{8'h01, 10'b1000000010, 100, 1'b0};

    key = 1'b0; sw = 8'h3C; load = 1'b0; trans_en = 1'b0;
    pdo = 8'h00; din_drv = 1'b1; loop_en = 1'b0;

    step(2);
    check("rst_dout", dout, 1);
    check("rst_pdi", pdi, 8'h00);
    check("rst_ledr", ledr, 8'h00);
    check("rst_sent", char_sent, 0);
    check("rst_recv", char_recv, 0);
    key = 1'b1;
    step(3);

    for (int i = 0; i < 5; i++) begin
      sw = vecs[i].data ^ 8'hC3;
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // load edge with transEn low must not start a frame
    loop_en = 1'b1; trans_en = 1'b0; pdo = 8'h5A;
    s0 = sent_seen; r0 = recv_seen; bad_cyc = 0;
    load = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if (dout !== 1'b1) bad_cyc++;
    end
    load = 1'b0;
    check("noen_line_bad_cycles", bad_cyc, 0);
    check("noen_sent_pulses", sent_seen - s0, 0);
    check("noen_recv_pulses", recv_seen - r0, 0);
    step(3);

    // 5-cycle low glitch is rejected
    loop_en = 1'b0; din_drv = 1'b1;
    step(4);
    r0 = recv_seen;
    din_drv = 1'b0;
    step(5);
    din_drv = 1'b1;
    step(200);
    check("glitch_recv_pulses", recv_seen - r0, 0);
    check("glitch_pdi", pdi, 8'h01);

    // 0x55 with stop bit 0 is discarded
    r0 = recv_seen;
    send_serial(8'h55, 1'b0);
    step(20);
    din_drv = 1'b1;
    step(40);
    check("frame_err_recv_pulses", recv_seen - r0, 0);
    check("frame_err_pdi", pdi, 8'h01);
    check("frame_err_ledr", ledr, 8'h01);

    // receiver re-arms after the line returns high
    r0 = recv_seen;
    send_serial(8'h3C, 1'b1);
    din_drv = 1'b1;
    step(40);
    check("rearm_recv_pulses", recv_seen - r0, 1);
    check("rearm_pdi", pdi, 8'h3C);

    // reset mid-transmit and mid-receive
    loop_en = 1'b1; trans_en = 1'b1; pdo = 8'h00;
    s0 = sent_seen; r0 = recv_seen;
    load = 1'b1;
    step(10);
    load = 1'b0;
    step(70);
    key = 1'b0;
    step(1);
    check("midrst_dout", dout, 1);
    check("midrst_pdi", pdi, 8'h00);
    check("midrst_ledr", ledr, 8'h00);
    check("midrst_sent", char_sent, 0);
    check("midrst_recv", char_recv, 0);
    key = 1'b1;
    bad_cyc = 0;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if (dout !== 1'b1) bad_cyc++;
    end
    check("midrst_line_bad_cycles", bad_cyc, 0);
    check("midrst_sent_pulses", sent_seen - s0, 0);
    check("midrst_recv_pulses", recv_seen - r0, 0);
    check("midrst_pdi_after", pdi, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/communication.md
COMMUNICATION -- requirements
Module: communication

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 16: clock cycles per serial bit period.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port KEY, input, 1 bit [0:0]: KEY[0] is the synchronous, active-low reset.
REQ-004 SHALL have port SW, input, 8 bits: reserved; it has no effect on behaviour.
REQ-005 SHALL have port load, input, 1 bit: transmit request; acted on at its rising edge.
REQ-006 SHALL have port transEn, input, 1 bit: transmitter enable.
REQ-007 SHALL have port parallelDataOut, input, 8 bits: character to transmit.
REQ-008 SHALL have port dataIn, input, 1 bit: serial receive line; idles high.
REQ-009 SHALL have port dataOut, output, 1 bit: serial transmit line; idles high.
REQ-010 SHALL have port parallelDataIn, output, 8 bits: last correctly received character.
REQ-011 SHALL have port charSent, output, 1 bit: one-cycle pulse marking transmit-frame completion.
REQ-012 SHALL have port charReceived, output, 1 bit: one-cycle pulse marking a valid received character.
REQ-013 SHALL have port LEDR, output, 8 bits: always equal to parallelDataIn.

Function
REQ-014 Frame format SHALL be 10 bits, each BIT_CYCLES cycles long: start 0, eight data bits LSB first, stop 1.
REQ-015 Transmitter SHALL have two states, IDLE and SEND.
REQ-016 A load rising edge (registered previous value 0, current 1) seen in IDLE with transEn=1 SHALL capture parallelDataOut and enter SEND.
REQ-017 dataOut SHALL drive the start bit from the clock edge after the capture edge, for exactly 10*BIT_CYCLES cycles of frame.
REQ-018 load edges during SEND, or with transEn=0, SHALL be ignored.
REQ-019 Holding load high SHALL NOT retrigger a transmission.
REQ-020 Deasserting transEn mid-frame SHALL NOT abort the frame.
REQ-021 After the last stop-bit cycle the transmitter SHALL return to IDLE with dataOut=1, and charSent SHALL be 1 for exactly that first IDLE cycle.
REQ-022 dataIn SHALL pass through a 2-flop synchronizer before any receiver logic.
REQ-023 Receiver SHALL have four states: IDLE, START, DATA, STOP.
REQ-024 IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-025 In START the line SHALL be resampled at count BIT_CYCLES/2; low continues to DATA, high returns to IDLE (glitch rejection).
REQ-026 In DATA the receiver SHALL take eight samples, each BIT_CYCLES after the previous one, shifting LSB first.
REQ-027 In STOP the receiver SHALL take one sample BIT_CYCLES later.
REQ-028 If the stop sample is 1, parallelDataIn SHALL load the shift register on the next edge and charReceived SHALL pulse for one cycle at that same edge; the receiver SHALL then return to IDLE.
REQ-029 If the stop sample is 0 (framing error), the data SHALL be discarded, parallelDataIn held, no pulse generated, and the receiver SHALL wait in IDLE for dataIn=1 before arming again.
REQ-030 Transmitter and receiver SHALL operate independently and simultaneously; looping dataOut to dataIn SHALL work.

Reset
REQ-031 While KEY[0]=0 at a rising edge, all state SHALL reset: both FSMs IDLE, counters 0, dataOut=1, parallelDataIn=0, LEDR=0, charSent=0, charReceived=0, load-edge register=0.
REQ-032 Reset mid-frame SHALL abort both directions immediately; no charSent or charReceived pulse SHALL be emitted for the aborted frame.

Verification
REQ-033 Reset with KEY[0]=0 for 2 cycles -> dataOut=1, parallelDataIn=0x00, LEDR=0x00, both pulses 0.
REQ-034 transEn=1, parallelDataOut=0x72, load held high for 16 cycles -> dataOut sequence 0,0,1,0,0,1,1,1,0,1 with 16 cycles per bit; charSent high for 1 cycle, 160 cycles after the start bit began; exactly one frame sent.
REQ-035 dataOut looped to dataIn during the 0x72 frame -> single charReceived pulse; parallelDataIn=0x72; LEDR=0x72.
REQ-036 dataIn low for 5 cycles then high; separately, a 0x55 frame with stop bit 0 -> no charReceived pulse; parallelDataIn unchanged.
REQ-037 load edge during SEND, or with transEn=0 -> ignored; frame in progress continues unchanged.
REQ-038 KEY[0]=0 mid-transmit and mid-receive -> dataOut=1 on the next cycle; no pulses; outputs equal their reset values.
